// File: rtl/apple_bus_pkg.sv
// Shared constants and types for the Apple II slot bus initiator.
package apple_bus_pkg;

    localparam logic [15:0] IO_BASE      = 16'hC080;
    localparam logic [15:0] SLOTROM_BASE = 16'hC000;
    localparam logic [15:0] EXPROM_LO    = 16'hC800;
    localparam logic [15:0] EXPROM_HI    = 16'hCFFF;
    localparam logic [15:0] CLR_EXP_ADDR = 16'hCFFF;

    typedef enum logic {
        PH1 = 1'b0,
        PH0 = 1'b1
    } phase_e;

    // True when a lies in the inclusive window [lo, hi].
    function automatic logic addr_in(input logic [15:0] a, input logic [15:0] lo,
                                     input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/apple_bus_master_bus_phase_gen.sv
// phi0 generator: free-running phase counter plus PH1/PH0 FSM.
// last_ph1/last_ph0 flag the final fclk of each half-period.
module bus_phase_gen
    import apple_bus_pkg::*;
#(
    parameter int CLK_PER_PHASE = 4
) (
    input  logic fclk,
    input  logic reset,
    output logic phi0,
    output logic last_ph1,
    output logic last_ph0
);

    localparam int CW = (CLK_PER_PHASE > 1) ? $clog2(CLK_PER_PHASE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_PHASE - 1);

    phase_e        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_wrap;

    assign cnt_wrap = (cnt == CNT_LAST);

    // State and phase counter registers; counter wraps every half-period.
    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state <= PH1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_wrap ? '0 : cnt + 1'b1;
        end
    end

    // Toggle phase at the end of each half-period.
    always_comb begin
        state_nxt = state;
        case (state)
            PH1:     if (cnt_wrap) state_nxt = PH0;
            PH0:     if (cnt_wrap) state_nxt = PH1;
            default: state_nxt = PH1;
        endcase
    end

    assign phi0     = (state == PH0);
    assign last_ph1 = (state == PH1) && cnt_wrap;
    assign last_ph0 = (state == PH0) && cnt_wrap;

endmodule

// File: rtl/apple_bus_master.sv
// Apple II slot bus initiator: turns a valid/ready request into one
// 6502-style bus cycle and returns a one-fclk completion pulse.
// Optional: APPLE_BUS_CLR_EXP_EN makes the first post-reset cycle an
// internal read of $CFFF to clear card expansion-ROM latches.
module apple_bus_master
    import apple_bus_pkg::*;
#(
    parameter int CLK_PER_PHASE = 4,
    parameter int SLOT          = 6
) (
    input  logic        fclk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_rw,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        phi0,
    output logic [15:0] addr,
    output logic        rw,
    output logic        _devsel,
    output logic        _iosel,
    output logic        _iostrobe,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in
);

`ifdef APPLE_BUS_CLR_EXP_EN
    localparam logic CLR_EN = 1'b1;
`else
    localparam logic CLR_EN = 1'b0;
`endif

    localparam logic [15:0] DEV_LO = IO_BASE + 16'(SLOT * 16);
    localparam logic [15:0] DEV_HI = DEV_LO + 16'h000F;
    localparam logic [15:0] ROM_LO = SLOTROM_BASE + 16'(SLOT * 256);
    localparam logic [15:0] ROM_HI = ROM_LO + 16'h00FF;

    logic        last_ph1, last_ph0;
    logic        active;     // a transaction owns the current bus cycle
    logic        clr_q;      // current cycle is the internal latch-clear read
    logic        ph0_act;    // PH0 half of an active cycle
    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  wdata_q;

    bus_phase_gen #(.CLK_PER_PHASE(CLK_PER_PHASE)) u_phase (
        .fclk     (fclk),
        .reset    (reset),
        .phi0     (phi0),
        .last_ph1 (last_ph1),
        .last_ph0 (last_ph0)
    );

    // Requests are only taken on the cycle boundary, so a new cycle starts cleanly.
    assign req_ready = last_ph0;

    // Transaction registers: load on the cycle boundary, capture read data at PH0 end.
    // With the latch-clear feature the first cycle is pre-loaded as a $CFFF read.
    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            active     <= CLR_EN;
            clr_q      <= CLR_EN;
            addr_q     <= CLR_EN ? CLR_EXP_ADDR : 16'h0000;
            rw_q       <= 1'b1;
            wdata_q    <= 8'h00;
            resp_valid <= 1'b0;
            resp_rdata <= 8'h00;
        end else begin
            resp_valid <= 1'b0;
            if (last_ph0) begin
                if (active && !clr_q) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= rw_q ? data_in : 8'h00;
                end
                clr_q <= 1'b0;
                if (req_valid) begin
                    active  <= 1'b1;
                    addr_q  <= req_addr;
                    rw_q    <= req_rw;
                    wdata_q <= req_wdata;
                end else begin
                    active <= 1'b0;
                    rw_q   <= 1'b1;
                end
            end
        end
    end

    // Select window: opens entering PH0 of an active cycle, closes entering PH1.
    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            ph0_act <= 1'b0;
        end else if (last_ph1) begin
            ph0_act <= active;
        end else if (last_ph0) begin
            ph0_act <= 1'b0;
        end
    end

    assign addr      = addr_q;
    assign rw        = rw_q;
    assign _devsel   = !(ph0_act && addr_in(addr_q, DEV_LO, DEV_HI));
    assign _iosel    = !(ph0_act && addr_in(addr_q, ROM_LO, ROM_HI));
    assign _iostrobe = !(ph0_act && addr_in(addr_q, EXPROM_LO, EXPROM_HI));
    assign data_oe   = ph0_act && !rw_q;
    assign data_out  = data_oe ? wdata_q : 8'h00;

endmodule

// File: tb/tb_apple_bus_master.sv
// Directed bench for apple_bus_master (CLK_PER_PHASE=4, SLOT=6).
// Build with APPLE_BUS_CLR_EXP_EN to cover the latch-clear start-up cycle.
module tb_apple_bus_master;

    logic        fclk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic        req_rw = 1'b1;
    logic [7:0]  req_wdata = 8'h00;
    logic [7:0]  data_in = 8'h00;
    logic        req_ready, resp_valid, phi0, rw, _devsel, _iosel, _iostrobe, data_oe;
    logic [7:0]  resp_rdata, data_out;
    logic [15:0] addr;

    int tests = 0;
    int fails = 0;

    apple_bus_master #(.CLK_PER_PHASE(4), .SLOT(6)) dut (
        .fclk(fclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .phi0(phi0), .addr(addr),
        .rw(rw), ._devsel(_devsel), ._iosel(_iosel), ._iostrobe(_iostrobe),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
    );

    always #5 fclk = ~fclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Release reset on a falling edge; count sampled fclk until req_ready.
    task automatic release_wait();
        int n, strb, cfff, resp;
        n = 0; strb = 0; cfff = 0; resp = 0;
        @(negedge fclk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            n++;
            if (!_iostrobe) strb++;
            if (addr == 16'hCFFF) cfff++;
            if (resp_valid) resp++;
            if (req_ready) break;
            @(negedge fclk);
        end
        chk("first_ready_lat", n, 8);
        chk("post_reset_resp", resp, 0);
`ifdef APPLE_BUS_CLR_EXP_EN
        chk("clr_iostrobe_cnt", strb, 4);
        chk("clr_addr_cfff_cnt", cfff, 8);
`else
        chk("idle_iostrobe_cnt", strb, 0);
`endif
    endtask

    // One request; checks the 8 bus fclk plus the completion pulse.
    task automatic run_txn(input string tag, input logic [15:0] a, input logic r,
                           input logic [7:0] wd, input logic [7:0] din,
                           input int e_dev, input int e_io, input int e_str);
        int addr_ok, rw_ok, dev, io, str, oe, dout_ok, early, outside;
        bit got;
        addr_ok = 0; rw_ok = 0; dev = 0; io = 0; str = 0; oe = 0;
        dout_ok = 0; early = 0; outside = 0; got = 0;
        req_valid = 1'b1; req_addr = a; req_rw = r; req_wdata = wd; data_in = din;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) begin got = 1; break; end
            @(negedge fclk);
        end
        chk({tag, "_accept"}, got, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge fclk);
            if (k == 1) req_valid = 1'b0;
            if (addr == a) addr_ok++;
            if (rw == r) rw_ok++;
            if (!_devsel) dev++;
            if (!_iosel) io++;
            if (!_iostrobe) str++;
            if (data_oe) oe++;
            if (data_out === (data_oe ? wd : 8'h00)) dout_ok++;
            if (resp_valid) early++;
            if (!phi0 && (!_devsel || !_iosel || !_iostrobe || data_oe)) outside++;
        end
        chk({tag, "_addr_hold"}, addr_ok, 8);
        chk({tag, "_rw_hold"}, rw_ok, 8);
        chk({tag, "_devsel_cnt"}, dev, e_dev);
        chk({tag, "_iosel_cnt"}, io, e_io);
        chk({tag, "_iostrobe_cnt"}, str, e_str);
        chk({tag, "_oe_cnt"}, oe, r ? 0 : 4);
        chk({tag, "_dout"}, dout_ok, 8);
        chk({tag, "_sel_in_ph1"}, outside, 0);
        chk({tag, "_early_resp"}, early, 0);
        @(negedge fclk);
        chk({tag, "_resp_valid"}, resp_valid, 1);
        chk({tag, "_resp_rdata"}, resp_rdata, r ? din : 8'h00);
        chk({tag, "_idle_rw"}, rw, 1);
        chk({tag, "_idle_addr"}, addr, a);
        @(negedge fclk);
        chk({tag, "_resp_single"}, resp_valid, 0);
    endtask

    initial begin
        int acc_t[3];
        int resp_t[3];
        int na, nr, rd_ok;
        bit pre_iosel;

        // Reset state
        #23;
        chk("rst_phi0", phi0, 0);
`ifdef APPLE_BUS_CLR_EXP_EN
        chk("rst_addr", addr, 16'hCFFF);
`else
        chk("rst_addr", addr, 16'h0000);
`endif
        chk("rst_rw", rw, 1);
        chk("rst_sels", {_devsel, _iosel, _iostrobe}, 3'b111);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 8'h00);

        release_wait();

        run_txn("rd_c600", 16'hC600, 1'b1, 8'h00, 8'hA9, 0, 4, 0);
        run_txn("wr_c0e3", 16'hC0E3, 1'b0, 8'h5A, 8'h77, 4, 0, 0);
        run_txn("rd_c800", 16'hC800, 1'b1, 8'h00, 8'h11, 0, 0, 4);
        run_txn("rd_cfff", 16'hCFFF, 1'b1, 8'h00, 8'h22, 0, 0, 4);
        run_txn("rd_c500", 16'hC500, 1'b1, 8'h00, 8'h33, 0, 0, 0);

        // Three queued reads with req_valid held high
        na = 0; nr = 0; rd_ok = 0;
        acc_t = '{0, 0, 0};
        resp_t = '{0, 0, 0};
        req_valid = 1'b1; req_addr = 16'hC600; req_rw = 1'b1; data_in = 8'h4C;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid) begin
                if (nr < 3) resp_t[nr] = c;
                if (resp_rdata == 8'h4C) rd_ok++;
                nr++;
            end
            if (req_valid && req_ready) begin
                if (na < 3) acc_t[na] = c;
                na++;
                @(posedge fclk);
                #1;
                if (na >= 3) req_valid = 1'b0;
                else req_addr = 16'hC600 + 16'(na);
            end
            @(negedge fclk);
        end
        chk("b2b_accepts", na, 3);
        chk("b2b_gap01", acc_t[1] - acc_t[0], 8);
        chk("b2b_gap12", acc_t[2] - acc_t[1], 8);
        chk("b2b_resps", nr, 3);
        chk("b2b_rdata", rd_ok, 3);
        chk("b2b_lat0", resp_t[0] - acc_t[0], 9);
        chk("b2b_lat2", resp_t[2] - acc_t[2], 9);

        // Reset in the 2nd PH0 fclk of a $C600 read
        req_valid = 1'b1; req_addr = 16'hC600; req_rw = 1'b1; data_in = 8'hA9;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) break;
            @(negedge fclk);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge fclk);
            if (k == 1) req_valid = 1'b0;
        end
        pre_iosel = _iosel;
        chk("mid_pre_iosel", pre_iosel, 0);
        reset = 1'b1;
        #1;
        chk("mid_iosel", _iosel, 1);
        chk("mid_phi0", phi0, 0);
        chk("mid_rw", rw, 1);
        chk("mid_req_ready", req_ready, 0);
        repeat (3) begin
            @(negedge fclk);
            chk("mid_resp_in_rst", resp_valid, 0);
        end
        release_wait();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
